regfile_mp: RTL and testbench
=============================

# regfile_mp

Parametrised multi-port integer register file with per-register valid tracking and a write-back scoreboard. It replaces the fixed 2-read/2-write register file in the CPU core. Read ports serve decode, write ports serve the normal and atomic write-back paths, and the allocation port is driven by issue so decode can detect read-after-write hazards.

## Interface
Parameters:
- XLEN, 32, data width of each register.
- NREGS, 32, number of architectural registers. Must be a power of two, at least 2.
- NRD, 2, number of read ports.
- NWR, 2, number of write ports. A higher port index has higher priority.
- AW, $clog2(NREGS), register address width (derived).

Ports (port i occupies slice [i*AW +: AW] or [i*XLEN +: XLEN]):
- clk  in  1  clock, rising edge.
- reset  in  1  reset, asynchronous, active-high.
- rs  in  NRD*AW  read addresses.
- rdata  out  NRD*XLEN  read data, combinational.
- rbusy  out  NRD  read operand still has an outstanding producer, combinational.
- wen  in  NWR  write enables.
- wd  in  NWR*AW  write destinations.
- wdata  in  NWR*XLEN  write data.
- alloc_en  in  1  issue allocates a destination.
- alloc_rd  in  AW  allocated destination.
- any_busy  out  1  OR of all scoreboard bits. Registered.

## Operation
- Storage: regs[NREGS] of XLEN bits, valid[NREGS], busy[NREGS].
- Register 0 is hardwired:
  - It always reads 0 and is never busy.
  - Writes to it are discarded.
  - alloc_rd = 0 is ignored.
- Reset (async) behaviour:
  - valid ← all 0 and busy ← all 0. regs contents are not reset.
  - While valid[r] = 0, a read of r returns 0.
- Writes:
  - A write on port j is effective when wen[j] = 1 and wd[j] ≠ 0.
  - At the clock edge, regs[wd[j]] ← wdata[j], valid[wd[j]] ← 1, busy[wd[j]] ← 0.
  - If several effective ports target the same register, the highest j wins. Other writes to distinct registers all commit.
- Allocation:
  - An effective alloc sets busy[alloc_rd] ← 1.
  - If alloc and a write target the same register in the same cycle, alloc wins and busy stays 1, because a newer producer exists.
- Read port i:
  - rs[i] = 0 gives rdata = 0 and rbusy = 0.
  - Otherwise rdata = regs[rs[i]] if valid, else 0.
  - rbusy[i] = busy[rs[i]].
  - With forwarding enabled (see Configuration), the forwarding rules override these.
- any_busy ← |busy_next. It is 0 after reset.

## Timing
- Read path: zero latency, purely combinational from rs, wen, wd, wdata and state.
- Write visibility:
  - Without forwarding, a write is visible at rdata in the cycle after the edge.
  - With forwarding, it is visible in the same cycle.
- Scoreboard: busy is set in the cycle after the alloc edge and cleared in the cycle after the write edge.
- Reset mid-operation:
  - All writes and allocs in flight are dropped.
  - rdata drops to 0 and rbusy to 0 immediately, without waiting for a clock edge.
- Outputs during reset: rdata = 0, rbusy = 0, any_busy = 0.

## Configuration
- REGFILE_BYPASS_EN defined:
  - For each read port, the highest-index effective write with wd[j] = rs[i] (rs[i] ≠ 0) forwards wdata[j] to rdata[i].
  - rbusy[i] is forced to 0 in that cycle, unless an alloc to the same register occurs in the same cycle.
- REGFILE_BYPASS_EN undefined:
  - No forwarding. rdata and rbusy reflect registered state only.
  - Decode must hold for one extra cycle after write-back.

## Test plan
- Reset then read: assert reset, release, read registers 1..31 on all ports -> rdata = 0 and rbusy = 0 everywhere; any_busy = 0.
- Write collision: wen = 2'b11, wd = {5, 5}, wdata = {0xAAAA_0001 (port 1), 0x0000_0002 (port 0)} -> the next cycle reads 0xAAAA_0001 from r5. A distinct-target pair (r6 = 7, r9 = 3) commits both.
- Register 0: write 0xDEAD_BEEF to r0 and alloc r0 -> r0 reads 0, is never busy, and any_busy stays 0.
- Scoreboard: alloc r3, then 2 idle cycles -> rbusy for rs = 3 is 1 and any_busy = 1. Write r3 = 0x55 -> busy clears the next cycle; with forwarding, rbusy is 0 and rdata = 0x55 in the write cycle itself.
- Alloc/write collision: write r4 = 0x10 and alloc r4 in the same cycle -> busy[4] = 1 and valid[4] = 1; r4 reads 0x10 with rbusy = 1.
- Async reset mid-stream: with r7 = 0x1234 and busy[8] = 1, pulse reset between edges -> r7 reads 0 and rbusy for r8 = 0 immediately, before the next clk edge.

Source files
------------

// File: rtl/regfile_mp_if.sv
// Bundles the decode, write-back and issue signals of the register file.
// master = CPU core side, slave = register file.
interface regfile_mp_if #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NRD   = 2,
  parameter int NWR   = 2,
  parameter int AW    = $clog2(NREGS)
);

  logic [NRD*AW-1:0]   rs;
  logic [NRD*XLEN-1:0] rdata;
  logic [NRD-1:0]      rbusy;
  logic [NWR-1:0]      wen;
  logic [NWR*AW-1:0]   wd;
  logic [NWR*XLEN-1:0] wdata;
  logic                alloc_en;
  logic [AW-1:0]       alloc_rd;
  logic                any_busy;

  modport master (
    output rs, wen, wd, wdata, alloc_en, alloc_rd,
    input  rdata, rbusy, any_busy
  );

  modport slave (
    input  rs, wen, wd, wdata, alloc_en, alloc_rd,
    output rdata, rbusy, any_busy
  );

endinterface

// File: rtl/regfile_mp.sv
// Multi-port register file with per-register valid bits and a write-back scoreboard.
// Define REGFILE_BYPASS_EN to forward same-cycle write-back data to the read ports.
module regfile_mp #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NRD   = 2,
  parameter int NWR   = 2,
  parameter int AW    = $clog2(NREGS)
) (
  input logic          clk,
  input logic          reset,
  regfile_mp_if.slave  bus
);

  logic [XLEN-1:0]  r_regs [NREGS];
  logic [NREGS-1:0] r_valid;
  logic [NREGS-1:0] r_busy;
  logic             r_anyBusy;

  logic [NREGS-1:0] w_wrHit;
  logic [XLEN-1:0]  w_wrData [NREGS];
  logic [NREGS-1:0] w_allocHit;
  logic [NREGS-1:0] w_validNext;
  logic [NREGS-1:0] w_busyNext;

  // Later ports overwrite earlier ones, so the highest effective port wins per register.
  always_comb begin
    logic [AW-1:0] dest;
    dest = '0;
    for (int r = 0; r < NREGS; r++) begin
      w_wrHit[r]  = 1'b0;
      w_wrData[r] = '0;
    end
    for (int j = 0; j < NWR; j++) begin
      dest = bus.wd[j*AW +: AW];
      if (bus.wen[j] && (dest != '0)) begin
        w_wrHit[dest]  = 1'b1;
        w_wrData[dest] = bus.wdata[j*XLEN +: XLEN];
      end
    end
  end

  always_comb begin
    w_allocHit = '0;
    if (bus.alloc_en && (bus.alloc_rd != '0))
      w_allocHit[bus.alloc_rd] = 1'b1;
  end

  // An alloc in the same cycle as a write means a newer producer, so busy stays set.
  assign w_busyNext  = (r_busy & ~w_wrHit) | w_allocHit;
  assign w_validNext = r_valid | w_wrHit;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid   <= '0;
      r_busy    <= '0;
      r_anyBusy <= 1'b0;
    end else begin
      r_valid   <= w_validNext;
      r_busy    <= w_busyNext;
      r_anyBusy <= |w_busyNext;
    end
  end

  // Data is not reset; valid masks stale contents until the register is written again.
  always_ff @(posedge clk) begin
    for (int r = 0; r < NREGS; r++) begin
      if (w_wrHit[r])
        r_regs[r] <= w_wrData[r];
    end
  end

  always_comb begin
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] data;
    logic            busyBit;
    addr      = '0;
    data      = '0;
    busyBit   = 1'b0;
    bus.rdata = '0;
    bus.rbusy = '0;
    for (int i = 0; i < NRD; i++) begin
      addr    = bus.rs[i*AW +: AW];
      data    = '0;
      busyBit = 1'b0;
      if (!reset && (addr != '0)) begin
        if (r_valid[addr])
          data = r_regs[addr];
        busyBit = r_busy[addr];
`ifdef REGFILE_BYPASS_EN
        if (w_wrHit[addr]) begin
          data    = w_wrData[addr];
          busyBit = w_allocHit[addr];
        end
`endif
      end
      bus.rdata[i*XLEN +: XLEN] = data;
      bus.rbusy[i]              = busyBit;
    end
  end

  assign bus.any_busy = r_anyBusy;

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: expected values are queued as stimulus is applied
// and drained against the DUT outputs at each sample point.
module tb_regfile_mp;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int NRD   = 2;
  localparam int NWR   = 2;
  localparam int AW    = 5;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  localparam int KIND_DATA = 0;
  localparam int KIND_BUSY = 1;
  localparam int KIND_ANY  = 2;

  typedef struct {
    string       tag;
    int          kind;
    int          port;
    logic [31:0] value;
  } expT;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  expT  scoreboard [$];

  regfile_mp_if #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR), .AW(AW)) bus ();

  regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR), .AW(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input int port, input logic en, input logic [AW-1:0] addr,
                               input logic [31:0] data);
    bus.wen[port]              = en;
    bus.wd[port*AW +: AW]      = addr;
    bus.wdata[port*XLEN +: XLEN] = data;
  endtask

  task automatic clearInputs();
    bus.wen      = '0;
    bus.wd       = '0;
    bus.wdata    = '0;
    bus.alloc_en = 1'b0;
    bus.alloc_rd = '0;
  endtask

  task automatic setRead(input int port, input logic [AW-1:0] addr);
    bus.rs[port*AW +: AW] = addr;
  endtask

  task automatic pushExpected(input string tag, input int kind, input int port,
                              input logic [31:0] value);
    expT e;
    e.tag   = tag;
    e.kind  = kind;
    e.port  = port;
    e.value = value;
    scoreboard.push_back(e);
  endtask

  task automatic checkOutput(input bit waitEdge);
    expT         e;
    logic [31:0] observed;
    if (waitEdge)
      @(negedge clk);
    while (scoreboard.size() > 0) begin
      e = scoreboard.pop_front();
      case (e.kind)
        KIND_DATA: observed = bus.rdata[e.port*XLEN +: XLEN];
        KIND_BUSY: observed = {31'b0, bus.rbusy[e.port]};
        default:   observed = {31'b0, bus.any_busy};
      endcase
      checks++;
      assert (observed === e.value) else begin
        errors++;
        $error("[TB] FAIL %s: observed %h expected %h", e.tag, observed, e.value);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    bus.rs = '0;
    clearInputs();

    // Outputs held at zero while reset is asserted
    tick();
    setRead(0, 5'd5);
    setRead(1, 5'd1);
    pushExpected("rst_rdata0", KIND_DATA, 0, 32'h0);
    pushExpected("rst_rbusy0", KIND_BUSY, 0, 32'h0);
    pushExpected("rst_any", KIND_ANY, 0, 32'h0);
    checkOutput(1'b1);
    reset = 1'b0;

    // Every register reads zero and idle after reset
    tick();
    for (int r = 1; r < NREGS; r++) begin
      setRead(0, 5'(r));
      setRead(1, 5'(NREGS - r));
      #1;
      pushExpected($sformatf("init_rdata0_r%0d", r), KIND_DATA, 0, 32'h0);
      pushExpected($sformatf("init_rdata1_r%0d", NREGS - r), KIND_DATA, 1, 32'h0);
      pushExpected($sformatf("init_rbusy0_r%0d", r), KIND_BUSY, 0, 32'h0);
      pushExpected($sformatf("init_rbusy1_r%0d", NREGS - r), KIND_BUSY, 1, 32'h0);
      checkOutput(1'b0);
    end
    pushExpected("init_any", KIND_ANY, 0, 32'h0);
    checkOutput(1'b0);

    // Write collision on r5: port 1 wins
    tick();
    applyStimulus(0, 1'b1, 5'd5, 32'h0000_0002);
    applyStimulus(1, 1'b1, 5'd5, 32'hAAAA_0001);
    setRead(0, 5'd5);
    pushExpected("coll_same_cycle", KIND_DATA, 0, BYP ? 32'hAAAA_0001 : 32'h0);
    checkOutput(1'b1);
    tick();
    clearInputs();
    pushExpected("coll_r5", KIND_DATA, 0, 32'hAAAA_0001);
    checkOutput(1'b1);

    // Distinct targets both commit
    tick();
    applyStimulus(0, 1'b1, 5'd6, 32'h7);
    applyStimulus(1, 1'b1, 5'd9, 32'h3);
    tick();
    clearInputs();
    setRead(0, 5'd6);
    setRead(1, 5'd9);
    pushExpected("dist_r6", KIND_DATA, 0, 32'h7);
    pushExpected("dist_r9", KIND_DATA, 1, 32'h3);
    checkOutput(1'b1);

    // Register 0 ignores writes and allocs
    tick();
    applyStimulus(0, 1'b1, 5'd0, 32'hDEAD_BEEF);
    bus.alloc_en = 1'b1;
    bus.alloc_rd = 5'd0;
    setRead(0, 5'd0);
    pushExpected("r0_same_data", KIND_DATA, 0, 32'h0);
    pushExpected("r0_same_busy", KIND_BUSY, 0, 32'h0);
    checkOutput(1'b1);
    tick();
    clearInputs();
    pushExpected("r0_data", KIND_DATA, 0, 32'h0);
    pushExpected("r0_busy", KIND_BUSY, 0, 32'h0);
    pushExpected("r0_any", KIND_ANY, 0, 32'h0);
    checkOutput(1'b1);

    // Scoreboard: alloc r3, idle, then write-back clears it
    tick();
    bus.alloc_en = 1'b1;
    bus.alloc_rd = 5'd3;
    tick();
    clearInputs();
    tick();
    tick();
    setRead(0, 5'd3);
    pushExpected("sb_busy", KIND_BUSY, 0, 32'h1);
    pushExpected("sb_any", KIND_ANY, 0, 32'h1);
    pushExpected("sb_data", KIND_DATA, 0, 32'h0);
    checkOutput(1'b1);
    tick();
    applyStimulus(1, 1'b1, 5'd3, 32'h55);
    pushExpected("sb_wr_busy", KIND_BUSY, 0, BYP ? 32'h0 : 32'h1);
    pushExpected("sb_wr_data", KIND_DATA, 0, BYP ? 32'h55 : 32'h0);
    checkOutput(1'b1);
    tick();
    clearInputs();
    pushExpected("sb_clr_busy", KIND_BUSY, 0, 32'h0);
    pushExpected("sb_clr_data", KIND_DATA, 0, 32'h55);
    pushExpected("sb_clr_any", KIND_ANY, 0, 32'h0);
    checkOutput(1'b1);

    // Alloc and write to r4 in the same cycle: alloc wins
    tick();
    applyStimulus(0, 1'b1, 5'd4, 32'h10);
    bus.alloc_en = 1'b1;
    bus.alloc_rd = 5'd4;
    setRead(1, 5'd4);
    pushExpected("aw_same_data", KIND_DATA, 1, BYP ? 32'h10 : 32'h0);
    pushExpected("aw_same_busy", KIND_BUSY, 1, BYP ? 32'h1 : 32'h0);
    checkOutput(1'b1);
    tick();
    clearInputs();
    pushExpected("aw_data", KIND_DATA, 1, 32'h10);
    pushExpected("aw_busy", KIND_BUSY, 1, 32'h1);
    pushExpected("aw_any", KIND_ANY, 0, 32'h1);
    checkOutput(1'b1);

    // Async reset between edges clears visibility immediately
    tick();
    applyStimulus(0, 1'b1, 5'd7, 32'h1234);
    bus.alloc_en = 1'b1;
    bus.alloc_rd = 5'd8;
    tick();
    clearInputs();
    setRead(0, 5'd7);
    setRead(1, 5'd8);
    #1;
    pushExpected("ar_pre_r7", KIND_DATA, 0, 32'h1234);
    pushExpected("ar_pre_r8_busy", KIND_BUSY, 1, 32'h1);
    checkOutput(1'b0);
    applyStimulus(1, 1'b1, 5'd7, 32'h9999);
    #1;
    reset = 1'b1;
    #1;
    pushExpected("ar_r7", KIND_DATA, 0, 32'h0);
    pushExpected("ar_r8_busy", KIND_BUSY, 1, 32'h0);
    pushExpected("ar_any", KIND_ANY, 0, 32'h0);
    checkOutput(1'b0);
    tick();
    clearInputs();
    #2;
    reset = 1'b0;
    tick();
    pushExpected("ar_post_r7", KIND_DATA, 0, 32'h0);
    pushExpected("ar_post_r8_busy", KIND_BUSY, 1, 32'h0);
    pushExpected("ar_post_any", KIND_ANY, 0, 32'h0);
    checkOutput(1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
